// File: rtl/pipelined_cla_subtractor.sv
// Pipelined carry-lookahead subtractor: one GROUP-bit lookahead group resolved per stage,
// with a valid/ready handshake on both sides and full throughput.
module pipelined_cla_subtractor #(
   parameter int WIDTH = 8,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_min,
   input  logic [WIDTH-1:0] i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH:0]   o_result
);

   localparam int STAGES = WIDTH / GROUP;

   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0]            borrow_q, borrow_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;

   logic [STAGES-1:0]            load;
   logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_res;
   logic [STAGES-1:0]            src_cin, src_v;

   function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                                input logic [GROUP-1:0] b,
                                                input logic             cin);
      logic [GROUP-1:0] g, p;
      logic [GROUP:0]   c;
      logic             term, pp;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < GROUP; i++) begin
         term = g[i];
         pp   = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            term = term | (pp & g[j]);
            pp   = pp & p[j];
         end
         c[i+1] = term | (pp & cin);
      end
      return {c[GROUP], p ^ c[GROUP-1:0]};
   endfunction

   always_comb begin : advance_chain
      logic chain;
      chain = i_ready;
      load  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         chain   = ~valid_q[k] | chain;
         load[k] = chain;
      end
   end

   assign o_ready = load[0];

   // Stage 0 sees the raw operands with the subtrahend inverted and a carry-in of 1.
   always_comb begin
      src_a      = '0;
      src_b      = '0;
      src_res    = '0;
      src_cin    = '0;
      src_v      = '0;
      src_a[0]   = i_min;
      src_b[0]   = ~i_sub;
      src_cin[0] = 1'b1;
      src_v[0]   = i_valid;
      for (int k = 1; k < STAGES; k++) begin
         src_a[k]   = a_q[k-1];
         src_b[k]   = b_q[k-1];
         src_res[k] = res_q[k-1];
         src_cin[k] = ~borrow_q[k-1];
         src_v[k]   = valid_q[k-1];
      end
   end

   // Carry is stored inverted (as a borrow) so the reset value of 0 yields o_result = 0.
   always_comb begin
      logic [GROUP:0] grp;
      valid_d  = valid_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      grp      = '0;
      for (int k = 0; k < STAGES; k++) begin
         grp = cla_group(src_a[k][k*GROUP +: GROUP], src_b[k][k*GROUP +: GROUP], src_cin[k]);
         if (load[k]) begin
            valid_d[k] = src_v[k];
         end
         if (load[k] && src_v[k]) begin
            a_d[k]                     = src_a[k];
            b_d[k]                     = src_b[k];
            res_d[k]                   = src_res[k];
            res_d[k][k*GROUP +: GROUP] = grp[GROUP-1:0];
            borrow_d[k]                = ~grp[GROUP];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= '0;
         borrow_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
      end
   end

   assign o_valid  = valid_q[STAGES-1];
   assign o_result = {borrow_q[STAGES-1], res_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Self-checking bench for pipelined_cla_subtractor (WIDTH=8, GROUP=4): directed vectors,
// stall/reset sequences and randomized traffic against an arithmetic scoreboard.
module tb_pipelined_cla_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_valid, o_ready, o_valid, i_ready;
   logic [7:0] i_min, i_sub;
   logic [8:0] o_result;

   pipelined_cla_subtractor #(.WIDTH(8), .GROUP(4)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_min(i_min),
      .i_sub(i_sub), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] min;
      logic [7:0] sub;
      logic [8:0] exp;
   } vec_t;

   int         n_total = 0;
   int         n_pass  = 0;
   int         cyc     = 0;
   int         n_out   = 0;
   bit         lat_chk = 1'b0;
   logic [8:0] exp_q[$];
   int         cyc_q[$];

   task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic checki(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

   // One clock cycle: drive, sample at negedge, score transfers, advance past the edge.
   task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] e, input logic rdy, output logic acc);
      int c0;
      i_valid = v;
      i_min   = a;
      i_sub   = b;
      i_ready = rdy;
      @(negedge clk);
      acc = v & o_ready;
      if (o_valid && i_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL spurious_output: got %h expected no output", o_result);
         end else begin
            check9("result", o_result, exp_q.pop_front());
            c0 = cyc_q.pop_front();
            if (lat_chk) checki("latency", cyc - c0, 2);
         end
      end
      if (acc) begin
         exp_q.push_back(e);
         cyc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      vec_t       tbl[5];
      logic       acc;
      logic [7:0] s4m[5], s4s[5];
      logic [7:0] ra, rb;
      logic [8:0] hold;
      bit         have_hold;
      int         idx, base, cnt;

      tbl[0] = '{8'd107, 8'd72,  9'h023};
      tbl[1] = '{8'd5,   8'd23,  9'h1EE};
      tbl[2] = '{8'd0,   8'd255, 9'h101};
      tbl[3] = '{8'd255, 8'd0,   9'h0FF};
      tbl[4] = '{8'd0,   8'd0,   9'h000};
      s4m = '{8'd200, 8'd3, 8'd77, 8'd128, 8'd0};
      s4s = '{8'd100, 8'd9, 8'd77, 8'd1,   8'd0};

      // Reset state
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_min = '0; i_sub = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checki("rst_o_valid", int'(o_valid), 0);
         check9("rst_o_result", o_result, 9'h000);
         checki("rst_o_ready", int'(o_ready), 1);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'd0, 8'd0, 9'h000, 1'b1, acc);
         checki("idle_o_valid", int'(o_valid), 0);
         check9("idle_o_result", o_result, 9'h000);
         checki("idle_o_ready", int'(o_ready), 1);
      end

      // Single beat latency
      lat_chk = 1'b1;
      cycle(1'b1, 8'd10, 8'd7, 9'h003, 1'b1, acc);
      checki("single_accept", int'(acc), 1);
      checki("single_not_yet", int'(o_valid), 0);
      cycle(1'b0, 8'd0, 8'd0, 9'h000, 1'b1, acc);
      checki("single_valid", int'(o_valid), 1);
      check9("single_result", o_result, 9'h003);
      cycle(1'b0, 8'd0, 8'd0, 9'h000, 1'b1, acc);
      checki("single_gone", int'(o_valid), 0);

      // Back-to-back table
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, tbl[i].min, tbl[i].sub, tbl[i].exp, 1'b1, acc);
         checki("b2b_accept", int'(acc), 1);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 8'd0, 9'h000, 1'b1, acc);
      checki("b2b_drained", exp_q.size(), 0);

      // Stall with four items
      lat_chk   = 1'b0;
      idx       = 0;
      have_hold = 1'b0;
      hold      = '0;
      base      = n_out;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, s4m[idx], s4s[idx], ref_sub(s4m[idx], s4s[idx]), 1'b0, acc);
         if (acc) idx++;
         if (o_valid) begin
            if (have_hold) check9("stall_hold", o_result, hold);
            else begin
               hold      = o_result;
               have_hold = 1'b1;
            end
         end
      end
      checki("stall_accepted", idx, 2);
      checki("stall_o_ready", int'(o_ready), 0);
      checki("stall_o_valid", int'(o_valid), 1);
      for (int t = 0; t < 20 && (n_out - base) < 4; t++) begin
         cycle(idx < 4, s4m[idx], s4s[idx], ref_sub(s4m[idx], s4s[idx]), 1'b1, acc);
         if (acc) idx++;
      end
      checki("stall_delivered", n_out - base, 4);
      checki("stall_queue_empty", exp_q.size(), 0);

      // Reset while items are in flight
      lat_chk = 1'b1;
      cycle(1'b1, 8'd50, 8'd60, ref_sub(8'd50, 8'd60), 1'b1, acc);
      cycle(1'b1, 8'd9, 8'd8, ref_sub(8'd9, 8'd8), 1'b1, acc);
      rst = 1'b1;
      #1;
      checki("midrst_o_valid", int'(o_valid), 0);
      exp_q.delete();
      cyc_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      checki("postrst_o_valid", int'(o_valid), 0);
      base = n_out;
      cycle(1'b1, 8'd20, 8'd31, 9'h1F5, 1'b1, acc);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 8'd0, 9'h000, 1'b1, acc);
      checki("postrst_outputs", n_out - base, 1);

      // Randomized traffic
      lat_chk = 1'b0;
      cnt     = 0;
      ra      = 8'($urandom);
      rb      = 8'($urandom);
      for (int t = 0; t < 20000 && cnt < 1000; t++) begin
         cycle($urandom_range(0, 3) != 0, ra, rb, ref_sub(ra, rb), $urandom_range(0, 3) != 0, acc);
         if (acc) begin
            cnt++;
            ra = 8'($urandom);
            rb = 8'($urandom);
         end
      end
      for (int t = 0; t < 50 && exp_q.size() > 0; t++) cycle(1'b0, 8'd0, 8'd0, 9'h000, 1'b1, acc);
      checki("random_accepted", cnt, 1000);
      checki("random_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
